apb_uart_ctrl: RTL and testbench

APB slave controller that sequences a UART core on behalf of the bus master. Holds the UART configuration registers and buffers transmit and receive bytes in two small FIFOs. Drives the UART core through a valid/ready transmit handshake and a valid-pulse receive port, and raises a level interrupt. Sits between the APB interconnect and the UART serializer/deserializer.

---
 rtl/apb_uart_pkg.sv | 55 +++++
 rtl/uart_sync_fifo.sv | 66 ++++++
 rtl/apb_uart_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_apb_uart_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_uart_pkg
// Description : Shared definitions for the APB UART controller: register
//               offsets, STATUS/CTRL bit positions, baud floor, APB FSM
//               states and the decoded-operation encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_uart_pkg;

    // Register offsets, word index taken from paddr[4:2]
    localparam logic [2:0] REG_TXDATA = 3'd0;
    localparam logic [2:0] REG_RXDATA = 3'd1;
    localparam logic [2:0] REG_STATUS = 3'd2;
    localparam logic [2:0] REG_CTRL   = 3'd3;
    localparam logic [2:0] REG_BAUD   = 3'd4;

    // STATUS bit positions
    localparam int ST_TX_FULL  = 0;
    localparam int ST_TX_EMPTY = 1;
    localparam int ST_RX_FULL  = 2;
    localparam int ST_RX_EMPTY = 3;
    localparam int ST_OVERRUN  = 4;

    // CTRL bit positions
    localparam int CTRL_EN   = 0;
    localparam int CTRL_TXIE = 1;
    localparam int CTRL_RXIE = 2;

    // Smallest divisor the UART core can work with
    localparam logic [15:0] BAUD_MIN = 16'd16;

    // APB slave FSM; the SETUP phase is decoded while in IDLE
    typedef enum logic [0:0] {
        APB_IDLE   = 1'b0,
        APB_ACCESS = 1'b1
    } apb_state_e;

    // Side effect decided at SETUP, committed at the end of ACCESS
    typedef enum logic [2:0] {
        OP_NONE    = 3'd0,
        OP_TX_PUSH = 3'd1,
        OP_RX_POP  = 3'd2,
        OP_W1C     = 3'd3,
        OP_CTRL    = 3'd4,
        OP_BAUD    = 3'd5
    } apb_op_e;

    // Raise too-small divisors to the floor
    function automatic logic [15:0] clamp_baud(input logic [15:0] div);
        return (div < BAUD_MIN) ? BAUD_MIN : div;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_sync_fifo
// Description : Single-clock 8-bit FIFO with occupancy count. Pushes to a
//               full FIFO and pops from an empty one are ignored; full/empty
//               are judged on the state at the start of the cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    output logic [7:0]    pop_data,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign pop_data  = r_mem[r_rd_ptr];
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;

    // Storage, pointers and occupancy; power-of-2 depth lets pointers wrap freely
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/apb_uart_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : apb_uart_ctrl
// Description : APB slave that configures a UART core and buffers its TX/RX
//               bytes in two FIFOs. Zero-wait-state transfers: decode at
//               SETUP, response in ACCESS, side effects at the end of ACCESS.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_uart_ctrl
    import apb_uart_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] BAUD_RESET = 16'd434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    input  logic        pwrite,
    input  logic        psel,
    input  logic        penable,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [15:0] baud_div,
    output logic        uart_en,
    output logic        irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    apb_state_e    r_state, w_state_next;
    apb_op_e       r_op, w_op_next;
    logic [15:0]   r_wdata;
    logic [31:0]   r_prdata, w_prdata_next;
    logic          r_pready, w_pready_next;
    logic          r_pslverr, w_pslverr_next;
    logic          w_err;

    logic          r_en, r_txie, r_rxie, r_overrun, r_irq;
    logic [15:0]   r_baud;

    logic [7:0]    w_tx_head, w_rx_head;
    logic [CW-1:0] w_tx_count, w_rx_count;
    logic          w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic          w_commit, w_tx_push, w_tx_pop, w_rx_push, w_rx_pop, w_rx_overflow;
    logic [31:0]   w_status;
    logic          w_unused;

    // Byte-lane offset bits and upper write data carry no meaning here
    assign w_unused = &{1'b0, paddr[1:0], pwdata[31:16]};

    assign w_commit      = (r_state == APB_ACCESS);
    assign w_tx_push     = w_commit & (r_op == OP_TX_PUSH);
    assign w_rx_pop      = w_commit & (r_op == OP_RX_POP);
    assign w_tx_pop      = tx_valid & tx_ready;
    assign w_rx_push     = rx_valid & r_en;
    assign w_rx_overflow = w_rx_push & w_rx_full;

    uart_sync_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_tx_push),
        .push_data (r_wdata[7:0]),
        .pop       (w_tx_pop),
        .pop_data  (w_tx_head),
        .count     (w_tx_count),
        .full      (w_tx_full),
        .empty     (w_tx_empty)
    );

    uart_sync_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_rx_push),
        .push_data (rx_data),
        .pop       (w_rx_pop),
        .pop_data  (w_rx_head),
        .count     (w_rx_count),
        .full      (w_rx_full),
        .empty     (w_rx_empty)
    );

    // STATUS image as seen by a read issued this cycle
    always_comb begin
        w_status              = '0;
        w_status[ST_TX_FULL]  = w_tx_full;
        w_status[ST_TX_EMPTY] = w_tx_empty;
        w_status[ST_RX_FULL]  = w_rx_full;
        w_status[ST_RX_EMPTY] = w_rx_empty;
        w_status[ST_OVERRUN]  = r_overrun;
        w_status[10:8]        = 3'(w_tx_count);
        w_status[14:12]       = 3'(w_rx_count);
    end

    // APB state register plus registered response and pending operation
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= APB_IDLE;
            r_op      <= OP_NONE;
            r_wdata   <= '0;
            r_prdata  <= '0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_op      <= w_op_next;
            r_wdata   <= pwdata[15:0];
            r_prdata  <= w_prdata_next;
            r_pready  <= w_pready_next;
            r_pslverr <= w_pslverr_next;
        end
    end

    // Next state and SETUP-phase decode of the response and side effect
    always_comb begin
        w_state_next   = r_state;
        w_op_next      = OP_NONE;
        w_prdata_next  = '0;
        w_pready_next  = 1'b0;
        w_pslverr_next = 1'b0;
        w_err          = 1'b0;
        case (r_state)
            APB_IDLE: begin
                if (psel && !penable) begin
                    w_state_next  = APB_ACCESS;
                    w_pready_next = 1'b1;
                    if (paddr[31:5] != '0) begin
                        w_err = 1'b1;
                    end else begin
                        case (paddr[4:2])
                            REG_TXDATA: begin
                                if (!pwrite || w_tx_full) w_err = 1'b1;
                                else                      w_op_next = OP_TX_PUSH;
                            end
                            REG_RXDATA: begin
                                if (pwrite || w_rx_empty) begin
                                    w_err = 1'b1;
                                end else begin
                                    w_op_next     = OP_RX_POP;
                                    w_prdata_next = {24'b0, w_rx_head};
                                end
                            end
                            REG_STATUS: begin
                                if (pwrite) w_op_next     = OP_W1C;
                                else        w_prdata_next = w_status;
                            end
                            REG_CTRL: begin
                                if (pwrite) w_op_next     = OP_CTRL;
                                else        w_prdata_next = {29'b0, r_rxie, r_txie, r_en};
                            end
                            REG_BAUD: begin
                                if (pwrite) w_op_next     = OP_BAUD;
                                else        w_prdata_next = {16'b0, r_baud};
                            end
                            default: w_err = 1'b1;
                        endcase
                    end
                    if (w_err) begin
                        w_pslverr_next = 1'b1;
                        w_prdata_next  = '0;
                        w_op_next      = OP_NONE;
                    end
                end
            end
            APB_ACCESS: w_state_next = APB_IDLE;
            default:    w_state_next = APB_IDLE;
        endcase
    end

    // Configuration registers and sticky overrun; a new overrun beats W1C
    always_ff @(posedge clk) begin
        if (rst) begin
            r_en      <= 1'b0;
            r_txie    <= 1'b0;
            r_rxie    <= 1'b0;
            r_baud    <= BAUD_RESET;
            r_overrun <= 1'b0;
        end else begin
            if (w_commit && r_op == OP_CTRL) begin
                r_en   <= r_wdata[CTRL_EN];
                r_txie <= r_wdata[CTRL_TXIE];
                r_rxie <= r_wdata[CTRL_RXIE];
            end
            if (w_commit && r_op == OP_BAUD) begin
                r_baud <= clamp_baud(r_wdata);
            end
            if (w_rx_overflow) begin
                r_overrun <= 1'b1;
            end else if (w_commit && r_op == OP_W1C && r_wdata[ST_OVERRUN]) begin
                r_overrun <= 1'b0;
            end
        end
    end

    // Level interrupt, registered from the current FIFO and flag state
    always_ff @(posedge clk) begin
        if (rst) r_irq <= 1'b0;
        else     r_irq <= (r_txie & w_tx_empty) | (r_rxie & ~w_rx_empty) | r_overrun;
    end

    assign prdata   = r_prdata;
    assign pready   = r_pready;
    assign pslverr  = r_pslverr;
    assign tx_data  = w_tx_head;
    assign tx_valid = r_en & ~w_tx_empty;
    assign baud_div = r_baud;
    assign uart_en  = r_en;
    assign irq      = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_apb_uart_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_uart_ctrl
// Description : Self-checking bench for apb_uart_ctrl. Directed scenarios
//               followed by a random mix of bus accesses and received bytes,
//               all checked against a queue-based model of the register map.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_uart_ctrl;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] paddr, pwdata, prdata;
    logic        pwrite, psel, penable, pready, pslverr;
    logic [7:0]  tx_data, rx_data;
    logic        tx_valid, tx_ready, rx_valid;
    logic [15:0] baud_div;
    logic        uart_en, irq;

    int vectors = 0;
    int errors  = 0;

    // Reference model state
    logic [7:0]  txq[$];
    logic [7:0]  rxq[$];
    bit          m_en, m_txie, m_rxie, m_ovr;
    logic [15:0] m_baud;

    apb_uart_ctrl #(.FIFO_DEPTH(D), .BAUD_RESET(16'd434)) dut (
        .clk(clk), .rst(rst), .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite),
        .psel(psel), .penable(penable), .prdata(prdata), .pready(pready),
        .pslverr(pslverr), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .baud_div(baud_div), .uart_en(uart_en), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        txq.delete();
        rxq.delete();
        m_en = 0; m_txie = 0; m_rxie = 0; m_ovr = 0;
        m_baud = 16'd434;
    endtask

    function automatic logic [31:0] m_status();
        int tc = txq.size();
        int rc = rxq.size();
        logic [31:0] s = '0;
        s[0] = (tc == D);
        s[1] = (tc == 0);
        s[2] = (rc == D);
        s[3] = (rc == 0);
        s[4] = m_ovr;
        s[10:8]  = 3'(tc);
        s[14:12] = 3'(rc);
        return s;
    endfunction

    function automatic logic m_irq();
        return (m_txie && txq.size() == 0) || (m_rxie && rxq.size() != 0) || m_ovr;
    endfunction

    // Register-map behaviour: expected response and resulting state change
    task automatic model_access(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                                output logic [31:0] rd, output bit err);
        rd = '0;
        err = 0;
        if (addr[31:5] != 0) begin
            err = 1;
        end else begin
            case (addr[4:2])
                3'd0: if (!wr || txq.size() == D) err = 1; else txq.push_back(data[7:0]);
                3'd1: if (wr || rxq.size() == 0) err = 1; else rd = {24'b0, rxq.pop_front()};
                3'd2: if (wr) begin if (data[4]) m_ovr = 0; end else rd = m_status();
                3'd3: if (wr) begin m_en = data[0]; m_txie = data[1]; m_rxie = data[2]; end
                      else rd = {29'b0, m_rxie, m_txie, m_en};
                3'd4: if (wr) m_baud = (data[15:0] < 16) ? 16'd16 : data[15:0];
                      else rd = {16'b0, m_baud};
                default: err = 1;
            endcase
        end
    endtask

    // One APB transfer: SETUP now, ACCESS next cycle, returns in the cycle after
    task automatic do_apb(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                          input string tag);
        logic [31:0] er;
        bit          ee;
        model_access(wr, addr, data, er, ee);
        psel = 1; penable = 0; pwrite = wr; paddr = addr; pwdata = data;
        chk({tag, "/pready_setup"}, {31'b0, pready}, 32'd0);
        tick();
        penable = 1;
        chk({tag, "/pready"}, {31'b0, pready}, 32'd1);
        chk({tag, "/pslverr"}, {31'b0, pslverr}, {31'b0, ee});
        chk({tag, "/prdata"}, prdata, er);
        tick();
        psel = 0; penable = 0; pwrite = 0;
        chk({tag, "/pready_after"}, {31'b0, pready}, 32'd0);
        chk({tag, "/baud_div"}, {16'b0, baud_div}, {16'b0, m_baud});
        chk({tag, "/uart_en"}, {31'b0, uart_en}, {31'b0, m_en});
        if (!tx_ready)
            chk({tag, "/tx_valid"}, {31'b0, tx_valid}, {31'b0, m_en && txq.size() != 0});
    endtask

    task automatic rx_pulse(input logic [7:0] d);
        if (m_en) begin
            if (rxq.size() == D) m_ovr = 1;
            else                 rxq.push_back(d);
        end
        rx_valid = 1; rx_data = d;
        tick();
        rx_valid = 0;
    endtask

    // With EN already set, accept every queued byte one per cycle
    task automatic drain(input string tag);
        tx_ready = 1;
        while (txq.size() != 0) begin
            chk({tag, "/valid"}, {31'b0, tx_valid}, 32'd1);
            chk({tag, "/data"}, {24'b0, tx_data}, {24'b0, txq.pop_front()});
            tick();
        end
        chk({tag, "/empty"}, {31'b0, tx_valid}, 32'd0);
        tx_ready = 0;
    endtask

    initial begin
        rst = 1; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
        tx_ready = 0; rx_valid = 0; rx_data = 0;
        model_reset();
        tick(); tick(); tick();
        rst = 0;

        // Reset values
        chk("rst/prdata", prdata, 32'd0);
        chk("rst/pready", {31'b0, pready}, 32'd0);
        chk("rst/pslverr", {31'b0, pslverr}, 32'd0);
        chk("rst/tx_valid", {31'b0, tx_valid}, 32'd0);
        chk("rst/tx_data", {24'b0, tx_data}, 32'd0);
        chk("rst/baud", {16'b0, baud_div}, 32'd434);
        chk("rst/uart_en", {31'b0, uart_en}, 32'd0);
        chk("rst/irq", {31'b0, irq}, 32'd0);
        do_apb(0, 32'h10, 0, "rd_baud");
        do_apb(0, 32'h0C, 0, "rd_ctrl");
        do_apb(0, 32'h08, 0, "rd_status");

        // Single byte: tx_valid first seen two cycles after SETUP
        tx_ready = 1;
        do_apb(1, 32'h0C, 1, "en");
        do_apb(1, 32'h00, 32'h55, "tx55");
        chk("lat/valid", {31'b0, tx_valid}, 32'd1);
        chk("lat/data", {24'b0, tx_data}, 32'h55);
        void'(txq.pop_front());
        tick();
        chk("lat/popped", {31'b0, tx_valid}, 32'd0);
        tx_ready = 0;

        // Two bytes held with EN=0 stream out on consecutive cycles
        do_apb(1, 32'h0C, 0, "dis");
        do_apb(1, 32'h00, 32'h55, "tx55b");
        do_apb(1, 32'h00, 32'hA3, "txA3");
        do_apb(1, 32'h0C, 1, "en2");
        drain("pair");

        // TX overflow with EN=0, then ordered drain
        do_apb(1, 32'h0C, 0, "dis2");
        for (int i = 0; i < 5; i++) do_apb(1, 32'h00, $urandom_range(0, 255), "txfill");
        do_apb(0, 32'h08, 0, "st_txfull");
        do_apb(1, 32'h0C, 1, "en3");
        drain("fill");

        // RX overrun, reads in order, underflow, W1C
        for (int i = 0; i < 5; i++) rx_pulse(8'h10 + 8'(i));
        do_apb(0, 32'h08, 0, "st_ovr");
        for (int i = 0; i < 5; i++) do_apb(0, 32'h04, 0, "rxrd");
        do_apb(1, 32'h08, 32'h10, "w1c");
        do_apb(0, 32'h08, 0, "st_clr");

        // RX ignored while disabled
        do_apb(1, 32'h0C, 0, "dis3");
        rx_pulse(8'h77);
        do_apb(0, 32'h08, 0, "st_rxoff");

        // Interrupt timing
        do_apb(1, 32'h0C, 5, "rxie");
        rx_pulse(8'h3C);
        chk("irq/early", {31'b0, irq}, 32'd0);
        tick();
        chk("irq/rx", {31'b0, irq}, {31'b0, m_irq()});
        do_apb(0, 32'h04, 0, "irq_pop");
        tick();
        chk("irq/cleared", {31'b0, irq}, {31'b0, m_irq()});
        do_apb(1, 32'h0C, 3, "txie");
        tick();
        chk("irq/tx", {31'b0, irq}, {31'b0, m_irq()});

        // Baud clamp, unmapped and illegal accesses
        do_apb(1, 32'h10, 3, "baud3");
        do_apb(0, 32'h10, 0, "rd_baud16");
        do_apb(1, 32'h10, 32'h1234, "baud1234");
        do_apb(0, 32'h18, 0, "unmapped");
        do_apb(1, 32'h10C, 0, "hiaddr");
        do_apb(0, 32'h0C, 0, "ctrl_kept");
        do_apb(0, 32'h00, 0, "rd_txdata");
        do_apb(1, 32'h04, 0, "wr_rxdata");

        // Random mix of bus traffic and received bytes
        do_apb(1, 32'h0C, 1, "rnd_en");
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 6))
                0: do_apb(1, 32'h00, $urandom_range(0, 255), "r_tx");
                1: do_apb(0, 32'h04, 0, "r_rx");
                2: do_apb(0, 32'h08, 0, "r_st");
                3: rx_pulse(8'($urandom_range(0, 255)));
                4: do_apb(1, 32'h0C, $urandom_range(0, 7), "r_ctrl");
                5: do_apb(1, 32'h08, $urandom & 32'h1F, "r_w1c");
                default: do_apb($urandom_range(0, 1) == 1,
                                ($urandom_range(0, 1) == 1) ? 32'h14 + 4 * $urandom_range(0, 2)
                                                            : 32'($urandom_range(1, 255)) << 5,
                                $urandom, "r_bad");
            endcase
            tick();
            chk("r_irq", {31'b0, irq}, {31'b0, m_irq()});
        end
        do_apb(1, 32'h0C, 1, "rnd_drain_en");
        drain("rnd");

        // Reset during ACCESS of a TXDATA write with two bytes queued
        do_apb(1, 32'h0C, 0, "dis4");
        while (txq.size() < 2) do_apb(1, 32'h00, $urandom_range(0, 255), "pre");
        psel = 1; penable = 0; pwrite = 1; paddr = 32'h00; pwdata = 32'h99;
        tick();
        penable = 1; rst = 1;
        tick();
        rst = 0; psel = 0; penable = 0; pwrite = 0;
        model_reset();
        chk("abort/pready", {31'b0, pready}, 32'd0);
        chk("abort/tx_valid", {31'b0, tx_valid}, 32'd0);
        do_apb(0, 32'h08, 0, "abort_st");
        do_apb(1, 32'h0C, 1, "abort_en");
        tick(); tick();
        chk("abort/no_tx", {31'b0, tx_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
